// File: rtl/xge_clear_pulse_gen_if.sv
// Button-conditioning bus: raw pins in, debounced level, clear strobes and debug counters out.
// No valid/ready: clear_pulse is a fire-and-forget strobe that the XGbE core must accept in full.
interface xge_clear_pulse_gen_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0]   sw_raw;
    logic [N_SW-1:0]   sw_level;
    logic [N_SW-1:0]   clear_pulse;
    logic [N_SW*8-1:0] press_count;

    modport master (output sw_raw, input sw_level, clear_pulse, press_count);
    modport slave  (input sw_raw, output sw_level, clear_pulse, press_count);
endinterface

// File: rtl/xge_clear_pulse_gen.sv
// Per-button synchronise, debounce and fixed-width clear-pulse generation for the XGbE
// status-clear inputs, with debounced level and saturating press counters for debug.
module xge_clear_pulse_gen #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_CYCLES    = 16,
    parameter bit SW_ACTIVE_LOW   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    xge_clear_pulse_gen_if.slave   bus,
    output logic [N_SW-1:0]        pulse_state
);
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] P_LAST   = PCW'(PULSE_CYCLES - 1);
    localparam logic           RELEASED = SW_ACTIVE_LOW;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [N_SW-1:0]   sync1;
    logic [N_SW-1:0]   sync2;
    logic [N_SW-1:0]   synced;
    logic [N_SW-1:0]   level_v;
    logic [N_SW-1:0]   pulse_v;
    logic [N_SW*8-1:0] count_v;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= {N_SW{RELEASED}};
            sync2 <= {N_SW{RELEASED}};
        end else begin
            sync1 <= bus.sw_raw;
            sync2 <= sync1;
        end
    end

    // Normalise polarity once, after the synchroniser: 1 = pressed from here on.
    assign synced = SW_ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        logic [CW-1:0]  db_cnt;
        logic           stable;
        logic           accept;
        logic           press;
        state_t         state;
        state_t         state_nxt;
        logic [PCW-1:0] p_cnt;
        logic [PCW-1:0] p_cnt_nxt;
        logic [7:0]     count;

        assign accept = (synced[i] != stable) && (db_cnt == DB_LAST);
        assign press  = accept && synced[i];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                db_cnt <= '0;
                stable <= 1'b0;
            end else if (synced[i] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= synced[i];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state <= IDLE;
                p_cnt <= '0;
            end else begin
                state <= state_nxt;
                p_cnt <= p_cnt_nxt;
            end
        end

        // A press in either state (re)loads the full width; nothing is queued.
        always_comb begin
            state_nxt = state;
            p_cnt_nxt = p_cnt;
            case (state)
                IDLE: begin
                    if (press) begin
                        state_nxt = ACTIVE;
                        p_cnt_nxt = P_LAST;
                    end
                end
                ACTIVE: begin
                    if (press) begin
                        p_cnt_nxt = P_LAST;
                    end else if (p_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        p_cnt_nxt = p_cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    p_cnt_nxt = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                count <= '0;
            end else if (press && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
        end

        assign level_v[i]        = stable;
        assign pulse_v[i]        = (state == ACTIVE);
        assign pulse_state[i]    = (state == ACTIVE);
        assign count_v[8*i +: 8] = count;
    end

    assign bus.sw_level    = level_v;
    assign bus.clear_pulse = pulse_v;
    assign bus.press_count = count_v;

endmodule

// File: tb/tb_xge_clear_pulse_gen.sv
// Directed bench for xge_clear_pulse_gen: drivers push expected pulse events, a negedge
// monitor pops and compares them, plus pulse-width and counter checks.
module tb_xge_clear_pulse_gen;
  localparam int N_SW = 4;
  localparam int DB   = 8;
  localparam int PW   = 4;
  localparam int W    = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_cnt[N_SW];

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xge_clear_pulse_gen_if #(.N_SW(N_SW)) bus ();
  logic [N_SW-1:0] pulse_state;

  xge_clear_pulse_gen #(
    .N_SW(N_SW),
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES(PW),
    .SW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .pulse_state(pulse_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press channels in mask (active-low pins); sw_level and clear_pulse rise DB+2 edges later.
  task automatic press(input logic [N_SW-1:0] mask);
    bus.sw_raw = bus.sw_raw & ~mask;
    exp_q.push_back({16'(cyc + DB + 2), mask, mask});
    for (int i = 0; i < N_SW; i++)
      if (mask[i]) m_cnt[i] = (m_cnt[i] == 255) ? 255 : m_cnt[i] + 1;
  endtask

  task automatic release_sw(input logic [N_SW-1:0] mask);
    bus.sw_raw = bus.sw_raw | mask;
  endtask

  task automatic check_counts(input string name);
    check(name, bus.press_count,
          {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
  endtask

  // Monitor: any rise of clear_pulse or sw_level must match the head of the expected queue.
  logic [N_SW-1:0] prev_cp, prev_lv, rise_cp, rise_lv;
  logic [W-1:0]    head;
  int              run[N_SW];

  always @(negedge clk) begin
    if (!rstn) begin
      prev_cp = '0;
      prev_lv = '0;
      for (int i = 0; i < N_SW; i++) run[i] = 0;
    end else begin
      rise_cp = bus.clear_pulse & ~prev_cp;
      rise_lv = bus.sw_level & ~prev_lv;
      if ((rise_cp != '0) || (rise_lv != '0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {16'(cyc), rise_cp, rise_lv}, '0);
        end else begin
          head = exp_q.pop_front();
          check("pulse_event", {16'(cyc), rise_cp, rise_lv}, head);
        end
      end
      for (int i = 0; i < N_SW; i++) begin
        if (bus.clear_pulse[i]) begin
          run[i]++;
        end else if (prev_cp[i]) begin
          check($sformatf("pulse_width_ch%0d", i), run[i], PW);
          run[i] = 0;
        end
      end
      prev_cp = bus.clear_pulse;
      prev_lv = bus.sw_level;
    end
  end

  initial begin
    for (int i = 0; i < N_SW; i++) m_cnt[i] = 0;
    bus.sw_raw = 4'hF;
    rstn = 1'b0;

    // 1: outputs stay 0 while reset is held, whatever the pins do
    for (int k = 0; k < 4; k++) begin
      wait_cycles(2);
      bus.sw_raw = 4'($urandom_range(0, 15));
      #2;
      check("reset_outputs", {bus.sw_level, bus.clear_pulse, bus.press_count, pulse_state}, '0);
    end
    bus.sw_raw = 4'hF;
    wait_cycles(1);
    rstn = 1'b1;
    wait_cycles(20);
    check("post_reset_idle", {bus.sw_level, bus.clear_pulse, bus.press_count}, '0);

    // 2: single clean press on ch0
    press(4'b0001);
    wait_cycles(20);
    check("t2_queue_drained", exp_q.size(), 0);
    check_counts("t2_counts");
    release_sw(4'b0001);
    wait_cycles(14);
    check("t2_level_released", bus.sw_level, 4'b0000);

    // 3: bouncy press on ch1, acceptance timed from the final low
    bus.sw_raw[1] = 1'b0;
    wait_cycles(5);
    bus.sw_raw[1] = 1'b1;
    wait_cycles(1);
    press(4'b0010);
    wait_cycles(20);
    check("t3_queue_drained", exp_q.size(), 0);
    check_counts("t3_counts");
    release_sw(4'b0010);
    wait_cycles(14);

    // 4: 300 press/release cycles on ch2, counter saturates
    for (int n = 0; n < 300; n++) begin
      press(4'b0100);
      wait_cycles(12);
      release_sw(4'b0100);
      wait_cycles(12);
    end
    check("t4_queue_drained", exp_q.size(), 0);
    check_counts("t4_counts");
    check("t4_ch2_saturated", bus.press_count[23:16], 8'hFF);

    // 5: simultaneous presses on ch0 and ch3
    press(4'b1001);
    wait_cycles(20);
    check("t5_queue_drained", exp_q.size(), 0);
    check_counts("t5_counts");
    release_sw(4'b1001);
    wait_cycles(14);
    check("t5_level_released", bus.sw_level, 4'b0000);

    // 6: reset two cycles into a ch0 pulse
    press(4'b0001);
    wait_cycles(12);
    check("t6_pulse_in_flight", bus.clear_pulse, 4'b0001);
    #2;
    rstn = 1'b0;
    bus.sw_raw = 4'hF;
    #1;
    for (int i = 0; i < N_SW; i++) m_cnt[i] = 0;
    check("t6_abort_pulse", {bus.clear_pulse, pulse_state}, '0);
    check_counts("t6_counts_cleared");
    check("t6_queue_drained", exp_q.size(), 0);
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(30);
    check("t6_no_spurious", {bus.sw_level, bus.clear_pulse, bus.press_count}, '0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
